// File: rtl/corr_frame_serializer.sv
// Snapshots the correlation word bus on each integration pulse and streams it as a framed
// 7-bit-per-byte sequence: header (bit 7 set), MS-group-first data bytes, then an XOR checksum.
module corr_frame_serializer #(
    parameter int RESOLUTION = 14,
    parameter int NUM_WORDS  = 78
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              integration_clk_pulse,
    input  logic [NUM_WORDS*RESOLUTION-1:0]   data_in,
    output logic [7:0]                        tx_data,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    output logic                              busy,
    output logic                              frame_dropped,
    output logic [6:0]                        frame_seq
);
    localparam int GROUPS = (RESOLUTION + 6) / 7;
    localparam int WI_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int GI_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [WI_W-1:0] LAST_WORD = WI_W'(NUM_WORDS - 1);
    localparam logic [GI_W-1:0] LAST_GRP  = GI_W'(GROUPS - 1);

    typedef enum logic [1:0] {IDLE, HEADER, DATA, CHECKSUM} state_t;
    state_t state, state_nxt;

    logic [NUM_WORDS*RESOLUTION-1:0] snapshot;
    logic [WI_W-1:0]                 word_idx, sel_word;
    logic [GI_W-1:0]                 grp_idx, sel_grp;
    logic [6:0]                      checksum, seq_next, sel_byte;
    logic [RESOLUTION-1:0]           sel_val;
    logic [GROUPS*7-1:0]             sel_ext;
    logic                            accept, capture, drop, is_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (capture) state_nxt = HEADER;
            HEADER:   if (accept) state_nxt = DATA;
            DATA:     if (accept && is_last) state_nxt = CHECKSUM;
            CHECKSUM: if (accept) state_nxt = capture ? HEADER : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // A pulse is only taken when the previous frame is fully handed off this cycle.
    always_comb begin
        busy    = (state != IDLE);
        accept  = tx_valid && tx_ready;
        capture = integration_clk_pulse && ((state == IDLE) || (state == CHECKSUM && accept));
        drop    = integration_clk_pulse && !capture;
        is_last = (word_idx == LAST_WORD) && (grp_idx == LAST_GRP);
    end

    // word_idx/grp_idx name the byte on the bus; in DATA the mux looks one byte ahead.
    always_comb begin
        sel_word = word_idx;
        sel_grp  = grp_idx;
        if (state == DATA) begin
            if (grp_idx == LAST_GRP) begin
                sel_grp  = '0;
                sel_word = word_idx + 1'b1;
            end else begin
                sel_grp  = grp_idx + 1'b1;
            end
        end
        sel_val = '0;
        for (int k = 0; k < NUM_WORDS; k++)
            if (sel_word == WI_W'(k)) sel_val = snapshot[k*RESOLUTION +: RESOLUTION];
        sel_ext  = (GROUPS*7)'(sel_val);
        sel_byte = '0;
        for (int g = 0; g < GROUPS; g++)
            if (sel_grp == GI_W'(g)) sel_byte = sel_ext[(GROUPS-1-g)*7 +: 7];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot      <= '0;
            tx_data       <= '0;
            tx_valid      <= 1'b0;
            checksum      <= '0;
            seq_next      <= '0;
            frame_seq     <= '0;
            frame_dropped <= 1'b0;
            word_idx      <= '0;
            grp_idx       <= '0;
        end else begin
            frame_dropped <= drop;
            if (integration_clk_pulse) seq_next <= seq_next + 1'b1;
            if (capture) begin
                snapshot  <= data_in;
                tx_data   <= {1'b1, seq_next};
                tx_valid  <= 1'b1;
                frame_seq <= seq_next;
                checksum  <= '0;
                word_idx  <= '0;
                grp_idx   <= '0;
            end else if (accept) begin
                case (state)
                    HEADER: tx_data <= {1'b0, sel_byte};
                    DATA: begin
                        checksum <= checksum ^ tx_data[6:0];
                        if (is_last) begin
                            tx_data  <= {1'b0, checksum ^ tx_data[6:0]};
                            word_idx <= '0;
                            grp_idx  <= '0;
                        end else begin
                            tx_data  <= {1'b0, sel_byte};
                            word_idx <= sel_word;
                            grp_idx  <= sel_grp;
                        end
                    end
                    CHECKSUM: tx_valid <= 1'b0;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/corr_frame_serializer.md
Name: corr_frame_serializer

Overview:
Downstream stage of the correlator main block. On each integration_clk_pulse it snapshots the flat bus of accumulated correlation words. It then streams the snapshot as a framed byte sequence to the UART transmitter through a valid/ready byte handshake. The frame is self-synchronising: only header bytes have bit 7 set.

Parameters:
RESOLUTION, 14, bit width of each correlation word
NUM_WORDS, 78, words per frame (12 autocorrelations + 66 cross-correlations for 12 inputs)
GROUPS, ceil(RESOLUTION/7) (derived, 2 at default), 7-bit bytes per word

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
integration_clk_pulse  input  1  one-cycle pulse marking end of an integration period
data_in  input  NUM_WORDS*RESOLUTION  word k occupies bits [k*RESOLUTION +: RESOLUTION]
tx_data  output  8  byte offered to UART transmitter
tx_valid  output  1  tx_data is valid
tx_ready  input  1  UART accepts byte this cycle when tx_valid && tx_ready
busy  output  1  frame in progress (state != IDLE)
frame_dropped  output  1  one-cycle pulse when a pulse is ignored because busy
frame_seq  output  7  sequence number of the current or last frame

Behaviour:
- Reset (async): state=IDLE, tx_valid=0, tx_data=0, busy=0, frame_dropped=0, frame_seq=0, snapshot=0, checksum=0.
- FSM states are IDLE, HEADER, DATA and CHECKSUM.
- IDLE, on integration_clk_pulse:
  - register data_in into the snapshot.
  - load tx_data = 0x80 | seq_next[6:0], where seq_next is the internal counter.
  - assert tx_valid and go to HEADER.
  - first header byte is visible 1 cycle after the pulse.
- HEADER: hold tx_data and tx_valid until the handshake, then present data byte 0 (DATA).
- DATA, byte order:
  - word 0 first, through word NUM_WORDS-1.
  - within a word, most-significant 7-bit group first.
  - the word is zero-extended to GROUPS*7 bits.
  - each byte = {1'b0, group[6:0]}.
  - a new byte is presented on the cycle after each handshake; tx_valid stays high; no bubbles are required.
- Checksum:
  - XOR of all data bytes of the frame, bit 7 forced to 0.
  - cleared at frame start.
  - sent as the last byte in CHECKSUM; return to IDLE on its handshake.
- Frame length = 1 + NUM_WORDS*GROUPS + 1 bytes.
- Handshake rules: tx_data stable and tx_valid held while tx_valid && !tx_ready. tx_valid never deasserts before acceptance (except by reset).
- Sequence counter:
  - increments (mod 128) on every integration_clk_pulse, accepted or dropped, so the host detects gaps.
  - frame_seq reports the value placed in the most recent header.
- Pulse while busy (HEADER/DATA, or CHECKSUM without a handshake that cycle):
  - the pulse is ignored; the snapshot is unchanged.
  - frame_dropped pulses for 1 cycle and the sequence counter still increments.
- Pulse in CHECKSUM on the same cycle its handshake completes: captured. The next header is presented on the following cycle (back-to-back frames, no IDLE cycle).
- Snapshot isolation: changes on data_in after capture do not affect the frame in flight.
- Reset mid-frame: immediate abort. tx_valid=0 asynchronously and the partial frame is discarded. The next frame starts with header 0x80.
- Counters:
  - word index width clog2(NUM_WORDS).
  - group index width clog2(GROUPS).
  - wrap only at frame end.

Test Plan:
- Basic frame (NUM_WORDS=2, RESOLUTION=14, tx_ready=1), pulse with word0=0x3FFF, word1=0x0081 -> bytes 0x80,0x7F,0x7F,0x01,0x01,0x00 on 6 consecutive cycles starting 1 cycle after the pulse; busy low after the last byte.
- Second frame, word0=0x2A55, word1=0x0000 -> 0x81,0x54,0x55,0x00,0x00,0x01; frame_seq=1.
- Backpressure: random tx_ready with a 0-3 cycle stall per byte -> identical byte sequence, tx_data/tx_valid stable during each stall, no byte lost or duplicated.
- Drop: a second pulse mid-frame -> frame_dropped pulses once, the current frame is unchanged, and the next accepted frame header is 0x80|(seq+2).
- Back-to-back: pulse coincident with checksum acceptance -> next header on the following cycle. Also verify 128 frames wrap the header from 0xFF to 0x80.
- Reset mid-DATA -> tx_valid=0 and busy=0 the same cycle; the next pulse yields a header of 0x80 and a full frame.
